hlsm_launcher: RTL and testbench
================================

// Module: hlsm_launcher
// PURPOSE
//  Initiator side of the HLSM Start/Done handshake. Accepts one job on a valid/ready input,
//  drives the operand ports and Start of a generated HLSM core, and waits for Done.
//  It then captures z/x plus the cycle count into a result register with valid/ready.
//  Sits between the testbench/host and any generated HLSM datapath.
// PARAMETERS
//  DATA_W   32    width of operands a,b,c,start,inc and results z,x
//  CYC_W    16    width of the launch-to-Done cycle counter (saturating)
//  TIMEOUT  1024  watchdog limit in cycles (used only when HLSM_LAUNCH_TIMEOUT_EN is defined)
// PORTS
//  Clk         in   1       clock; all state updates on the rising edge
//  Rst         in   1       reset, asynchronous, active-low
//  job_valid   in   1       job offered
//  job_ready   out  1       job accepted when job_valid&job_ready
//  job_a/b/c   in   DATA_W  operands, signed
//  job_start   in   DATA_W  loop start operand, signed
//  job_inc     in   DATA_W  loop increment operand, signed
//  core_start  out  1       Start to the HLSM core
//  core_a/b/c, core_st, core_inc  out  DATA_W  registered operands to the core
//  core_done   in   1       Done from the core; level, stale-high until the core sees the next Start
//  core_z/x    in   DATA_W  core results, valid while core_done=1
//  res_valid   out  1       result held
//  res_ready   in   1       result consumed when res_valid&res_ready
//  res_z/x     out  DATA_W  captured results
//  res_cycles  out  CYC_W   cycles from first core_start=1 to Done capture, saturating
//  res_timeout out  1       1 = job aborted by watchdog (0 when the feature is absent)
//  busy        out  1       1 in any state other than IDLE
// BEHAVIOUR
//  Reset (Rst=0, async): state=IDLE; all outputs 0, including core operands, res_* and start_r.
//  FSM: IDLE -> ARM -> WAIT -> RESULT -> IDLE.
//  - IDLE: job_ready=1. On accept: latch operands to core_* regs, start_r<=1, armed<=0, cnt<=0 -> ARM.
//  - ARM: core_done is stale and is ignored. When core_done=0 is sampled: armed<=1 -> WAIT.
//  - WAIT: on core_done=1 with armed=1: capture core_z/x into res_z/x, res_cycles<=cnt,
//    start_r<=0, res_valid<=1 -> RESULT.
//  - RESULT: hold res_*. On res_valid&res_ready: res_valid<=0 -> IDLE.
//  - A new job is accepted no earlier than the cycle after the handshake.
//  core_start = start_r & ~(armed & core_done). This is combinational, so Start falls in the
//    same cycle Done is seen. The core, back in its state 0, must never re-launch. Glitch-free
//    because core_done is a register output.
//  cnt increments each cycle in ARM/WAIT; it saturates at 2^CYC_W-1 and does not wrap.
//  job_ready=0 outside IDLE; job_valid is ignored there. Operands are stable from accept to Done.
//  Edge cases:
//  - core_done already 0 at launch: ARM lasts exactly 1 cycle.
//  - core_done never drops in ARM: stay in ARM; only the watchdog exits.
//  - Rst asserted mid-job: immediate return to IDLE, core_start=0, any pending result dropped.
//  - res_ready held high: RESULT lasts 1 cycle.
// CONFIGURATION
//  HLSM_LAUNCH_TIMEOUT_EN defined:
//  - In ARM/WAIT, when cnt reaches TIMEOUT: start_r<=0, res_z/x<=0, res_cycles<=cnt,
//    res_timeout<=1, res_valid<=1 -> RESULT.
//  - res_timeout clears when the next job is accepted.
//  - If Done and the timeout hit on the same cycle, Done wins (normal capture, res_timeout=0).
//  Not defined: no watchdog logic; res_timeout is tied to 0 and a hung core holds busy forever.
// TESTING
//  1 Core model with Done after 12 cycles, a=3,b=4,c=5 -> core_start high 13 cycles, drops the
//    cycle Done=1, res_valid with core's z/x, res_cycles=13.
//  2 core_done stale=1 at launch, clears 1 cycle later -> no false capture; ARM lasts 2 cycles.
//  3 res_ready=0 for 5 cycles -> res_* stable, job_ready=0; 2nd job accepted only after consume.
//  4 Rst low while in WAIT -> all outputs 0 asynchronously, core_start=0 before the next edge.
//  5 TIMEOUT_EN, TIMEOUT=20, core never finishes -> res_timeout=1, res_cycles=20, res_z=0.
//  6 CYC_W=4 with 30-cycle core -> res_cycles=15 (saturated); back-to-back jobs give equal counts.

Source files
------------

// File: rtl/hlsm_launcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hlsm_launcher : Start/Done initiator for a generated HLSM core.          |
// | Accepts one job, launches the core, captures z/x and the cycle count.    |
// | Optional watchdog: define HLSM_LAUNCH_TIMEOUT_EN.                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hlsm_launcher #(
  parameter int DATA_W  = 32,
  parameter int CYC_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [DATA_W-1:0] job_a,
  input  logic [DATA_W-1:0] job_b,
  input  logic [DATA_W-1:0] job_c,
  input  logic [DATA_W-1:0] job_start,
  input  logic [DATA_W-1:0] job_inc,
  output logic              core_start,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  output logic [DATA_W-1:0] core_c,
  output logic [DATA_W-1:0] core_st,
  output logic [DATA_W-1:0] core_inc,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_z,
  input  logic [DATA_W-1:0] core_x,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_z,
  output logic [DATA_W-1:0] res_x,
  output logic [CYC_W-1:0]  res_cycles,
  output logic              res_timeout,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARM    = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              start_q, start_d;
  logic              armed_q, armed_d;
  logic [CYC_W-1:0]  cnt_q, cnt_d, cnt_next;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, st_q, st_d, inc_q, inc_d;
  logic [DATA_W-1:0] res_z_q, res_z_d, res_x_q, res_x_d;
  logic [CYC_W-1:0]  res_cycles_q, res_cycles_d;
  logic              res_valid_q, res_valid_d;
  logic              done_seen;

  assign done_seen = armed_q & core_done;
  assign cnt_next  = (cnt_q == {CYC_W{1'b1}}) ? cnt_q : cnt_q + CYC_W'(1);

`ifdef HLSM_LAUNCH_TIMEOUT_EN
  logic res_timeout_q, res_timeout_d;
  logic timeout_hit;
  assign timeout_hit = (64'(cnt_q) >= 64'(TIMEOUT));
  assign res_timeout = res_timeout_q;
`else
  // Constant 0; keeps TIMEOUT referenced in builds without the watchdog.
  assign res_timeout = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    armed_d      = armed_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    st_d         = st_q;
    inc_d        = inc_q;
    res_z_d      = res_z_q;
    res_x_d      = res_x_q;
    res_cycles_d = res_cycles_q;
    res_valid_d  = res_valid_q;
`ifdef HLSM_LAUNCH_TIMEOUT_EN
    res_timeout_d = res_timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          a_d     = job_a;
          b_d     = job_b;
          c_d     = job_c;
          st_d    = job_start;
          inc_d   = job_inc;
          start_d = 1'b1;
          armed_d = 1'b0;
          cnt_d   = '0;
`ifdef HLSM_LAUNCH_TIMEOUT_EN
          res_timeout_d = 1'b0;
`endif
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        cnt_d = cnt_next;
        // Done seen high here is left over from the previous job.
        if (!core_done) begin
          armed_d = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_next;
        if (done_seen) begin
          res_z_d      = core_z;
          res_x_d      = core_x;
          res_cycles_d = cnt_q;
          start_d      = 1'b0;
          res_valid_d  = 1'b1;
          state_d      = S_RESULT;
        end
      end
      default: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase
`ifdef HLSM_LAUNCH_TIMEOUT_EN
    if (timeout_hit && (state_q == S_ARM || (state_q == S_WAIT && !done_seen))) begin
      start_d       = 1'b0;
      res_z_d       = '0;
      res_x_d       = '0;
      res_cycles_d  = cnt_q;
      res_timeout_d = 1'b1;
      res_valid_d   = 1'b1;
      state_d       = S_RESULT;
    end
`endif
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      st_q         <= '0;
      inc_q        <= '0;
      res_z_q      <= '0;
      res_x_q      <= '0;
      res_cycles_q <= '0;
      res_valid_q  <= 1'b0;
`ifdef HLSM_LAUNCH_TIMEOUT_EN
      res_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      st_q         <= st_d;
      inc_q        <= inc_d;
      res_z_q      <= res_z_d;
      res_x_q      <= res_x_d;
      res_cycles_q <= res_cycles_d;
      res_valid_q  <= res_valid_d;
`ifdef HLSM_LAUNCH_TIMEOUT_EN
      res_timeout_q <= res_timeout_d;
`endif
    end
  end

  // Start drops in the very cycle Done is seen so the core never relaunches.
  assign core_start = start_q & ~done_seen;
  // Gated with reset so every output reads 0 while reset is held.
  assign job_ready  = (state_q == S_IDLE) & Rst;
  assign busy       = (state_q != S_IDLE);
  assign core_a     = a_q;
  assign core_b     = b_q;
  assign core_c     = c_q;
  assign core_st    = st_q;
  assign core_inc   = inc_q;
  assign res_z      = res_z_q;
  assign res_x      = res_x_q;
  assign res_cycles = res_cycles_q;
  assign res_valid  = res_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_hlsm_launcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hlsm_launcher : randomized bench with an HLSM core model and a        |
// | job-level reference model. Watchdog jobs only with HLSM_LAUNCH_TIMEOUT_EN.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hlsm_launcher;
  localparam int DW   = 16;
  localparam int CW   = 5;
  localparam int TO   = 20;
  localparam int CMAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [DW-1:0] job_a = '0, job_b = '0, job_c = '0, job_start = '0, job_inc = '0;
  logic          core_start;
  logic [DW-1:0] core_a, core_b, core_c, core_st, core_inc;
  logic          core_done;
  logic [DW-1:0] core_z, core_x;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_z, res_x;
  logic [CW-1:0] res_cycles;
  logic          res_timeout;
  logic          busy;

  hlsm_launcher #(.DATA_W(DW), .CYC_W(CW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a(job_a), .job_b(job_b), .job_c(job_c), .job_start(job_start), .job_inc(job_inc),
    .core_start(core_start), .core_a(core_a), .core_b(core_b), .core_c(core_c),
    .core_st(core_st), .core_inc(core_inc),
    .core_done(core_done), .core_z(core_z), .core_x(core_x),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .res_x(res_x),
    .res_cycles(res_cycles), .res_timeout(res_timeout), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- HLSM core model (environment) ----------------
  int      cur_lat = 1;
  bit      cm_hang = 1'b0;
  bit      core_clear_req = 1'b0;
  bit      cm_run;
  logic    cm_done;
  int      cm_left;
  logic [DW-1:0] cm_z, cm_x;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cm_run <= 1'b0; cm_done <= 1'b0; cm_left <= 0; cm_z <= '0; cm_x <= '0;
    end else begin
      if (core_clear_req && !cm_run) cm_done <= 1'b0;
      if (!cm_run && core_start && !cm_hang) begin
        cm_run  <= 1'b1;
        cm_done <= 1'b0;
        cm_left <= cur_lat;
        cm_z    <= core_a * core_b + core_c;
        cm_x    <= core_st - core_inc;
      end else if (cm_run) begin
        if (cm_left == 1) begin
          cm_run  <= 1'b0;
          cm_done <= 1'b1;
        end
        cm_left <= cm_left - 1;
      end
    end
  end

  assign core_done = cm_done;
  // Results are garbage whenever Done is low, exposing any early capture.
  assign core_z = cm_done ? cm_z : ~cm_z;
  assign core_x = cm_done ? cm_x : ~cm_x;

  // ---------------- job-level reference model ----------------
  typedef struct {
    logic [DW-1:0] a, b, c, st, inc, z, x;
    int            cyc;
    int            hi;
    bit            to;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t model(input logic [DW-1:0] a, b, c, st, inc,
                                 input int lat, input bit hang);
    exp_t e;
    e.a = a; e.b = b; e.c = c; e.st = st; e.inc = inc;
    e.z = a * b + c;
    e.x = st - inc;
    e.to = 1'b0;
    // Start is high from launch through the cycle before Done is seen: lat+1 cycles.
    e.hi  = lat + 1;
    e.cyc = (lat + 1 > CMAX) ? CMAX : lat + 1;
    if (hang) begin
      e.z = '0; e.x = '0; e.to = 1'b1;
      e.cyc = TO;
      e.hi  = TO + 1;
    end
    return e;
  endfunction

  int            last_cyc = 0;
  logic [DW-1:0] last_z = '0, last_x = '0;
  bit            last_to = 1'b0;
  int            last_rv_len = 0;

  initial begin : compare
    int hi_cnt;
    int rv_len;
    bit prev_rv;
    hi_cnt = 0; rv_len = 0; prev_rv = 1'b0;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        exp_q.delete();
        hi_cnt = 0; rv_len = 0; prev_rv = 1'b0;
      end else begin
        chk("job_ready_vs_busy", job_ready, !busy);
        if (busy) begin
          if (exp_q.size() == 0) chk("busy_without_job", busy, 0);
          else begin
            chk("core_a", core_a, exp_q[0].a);
            chk("core_b", core_b, exp_q[0].b);
            chk("core_c", core_c, exp_q[0].c);
            chk("core_st", core_st, exp_q[0].st);
            chk("core_inc", core_inc, exp_q[0].inc);
          end
        end
        if (res_valid) begin
          if (exp_q.size() == 0) chk("res_valid_without_job", res_valid, 0);
          else begin
            if (!prev_rv) begin
              chk("start_high_cycles", hi_cnt, exp_q[0].hi);
              hi_cnt = 0;
            end
            rv_len++;
            chk("res_z", res_z, exp_q[0].z);
            chk("res_x", res_x, exp_q[0].x);
            chk("res_cycles", res_cycles, exp_q[0].cyc);
            chk("res_timeout", res_timeout, exp_q[0].to);
            if (res_ready) begin
              last_cyc = res_cycles; last_z = res_z; last_x = res_x;
              last_to = res_timeout; last_rv_len = rv_len; rv_len = 0;
              void'(exp_q.pop_front());
            end
          end
        end
        if (core_start) hi_cnt++;
        prev_rv = res_valid;
        if (job_valid && job_ready)
          exp_q.push_back(model(job_a, job_b, job_c, job_start, job_inc, cur_lat, cm_hang));
      end
    end
  end

  // ---------------- result-side handshake ----------------
  int rr_mode = 1;  // 0 random, 1 always ready, 2 never ready
  initial forever begin
    @(posedge Clk); #1;
    case (rr_mode)
      0:       res_ready = ($urandom_range(0, 2) != 0);
      1:       res_ready = 1'b1;
      default: res_ready = 1'b0;
    endcase
  end

  // ---------------- job driver ----------------
  task automatic run_job(input logic [DW-1:0] a, b, c, st, inc,
                         input int lat, input bit hang, input int gap);
    int n;
    cur_lat = lat; cm_hang = hang;
    job_a = a; job_b = b; job_c = c; job_start = st; job_inc = inc;
    job_valid = 1'b1;
    n = 0;
    do begin @(negedge Clk); n++; end while (!job_ready && n < 200);
    if (!job_ready) chk("accept_wait_expired", job_ready, 1);
    n = 0;
    do begin
      @(posedge Clk); #1;
      // Noise on the job port while busy must be ignored.
      job_valid = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      job_a = DW'($urandom); job_b = DW'($urandom); job_c = DW'($urandom);
      job_start = DW'($urandom); job_inc = DW'($urandom);
      @(negedge Clk); n++;
    end while (busy && n < 400);
    if (busy) chk("job_finish_wait_expired", busy, 0);
    @(posedge Clk); #1;
    job_valid = 1'b0;
    cm_hang = 1'b0;
    repeat (gap) @(posedge Clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int n;
    #2;
    chk("reset_job_ready", job_ready, 0);
    chk("reset_core_start", core_start, 0);
    chk("reset_any_output", |{busy, res_valid, res_timeout, res_z, res_x, res_cycles,
                               core_a, core_b, core_c, core_st, core_inc}, 0);
    #10 Rst = 1'b1;
    @(posedge Clk); #1;

    // Fresh core, Done after 12 cycles.
    rr_mode = 1;
    run_job(16'd3, 16'd4, 16'd5, 16'd10, 16'd3, 12, 1'b0, 2);
    chk("t1_cycles_literal", last_cyc, 13);
    chk("t1_z_literal", last_z, 17);
    chk("t1_x_literal", last_x, 7);
    chk("t1_result_len_literal", last_rv_len, 1);

    // Done stale high at launch.
    run_job(16'd2, 16'd7, 16'd1, 16'd0, 16'd1, 5, 1'b0, 1);
    chk("t2_cycles_literal", last_cyc, 6);
    chk("t2_z_literal", last_z, 15);

    // Result held back while a second job is offered.
    rr_mode = 2;
    fork
      run_job(16'hFFFF, 16'd2, 16'd9, 16'd1, 16'hFFFF, 3, 1'b0, 0);
      begin
        n = 0;
        do begin @(negedge Clk); n++; end while (!res_valid && n < 200);
        repeat (5) @(posedge Clk);
        #2 rr_mode = 1;
      end
    join
    chk("t3_z_literal", last_z, 16'd7);
    chk("t3_x_literal", last_x, 16'd2);
    run_job(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 2, 1'b0, 1);
    chk("t3_second_job_cycles", last_cyc, 3);

    // Reset in the middle of WAIT.
    cur_lat = 20; cm_hang = 1'b0;
    job_a = 16'd9; job_b = 16'd9; job_c = 16'd9; job_start = 16'd9; job_inc = 16'd9;
    job_valid = 1'b1;
    n = 0;
    do begin @(negedge Clk); n++; end while (!job_ready && n < 50);
    @(posedge Clk); #1 job_valid = 1'b0;
    repeat (8) @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    chk("rst_mid_core_start", core_start, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_job_ready", job_ready, 0);
    chk("rst_mid_any_output", |{res_valid, res_timeout, res_z, res_x, res_cycles,
                                 core_a, core_b, core_c, core_st, core_inc}, 0);
    @(posedge Clk); @(posedge Clk);
    #2 Rst = 1'b1;
    @(posedge Clk); #1;
    run_job(16'd6, 16'd6, 16'd6, 16'd6, 16'd1, 4, 1'b0, 1);
    chk("post_rst_cycles", last_cyc, 5);

`ifdef HLSM_LAUNCH_TIMEOUT_EN
    run_job(16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 1, 1'b1, 1);
    chk("to_flag_literal", last_to, 1);
    chk("to_cycles_literal", last_cyc, TO);
    chk("to_z_literal", last_z, 0);
    run_job(16'd5, 16'd5, 16'd5, 16'd5, 16'd5, TO - 1, 1'b0, 1);
    chk("to_done_wins_flag", last_to, 0);
    chk("to_done_wins_cycles", last_cyc, TO);
`else
    run_job(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 29, 1'b0, 1);
    chk("cnt_30_literal", last_cyc, 30);
    run_job(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 30, 1'b0, 1);
    chk("cnt_max_literal", last_cyc, 31);
    run_job(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 40, 1'b0, 0);
    chk("cnt_sat_literal_a", last_cyc, 31);
    run_job(16'd7, 16'd2, 16'd3, 16'd4, 16'd5, 40, 1'b0, 0);
    chk("cnt_sat_literal_b", last_cyc, 31);
`endif

    // Randomized jobs.
    for (int i = 0; i < 40; i++) begin
      int  lat;
      bit  hang;
      hang = 1'b0;
`ifdef HLSM_LAUNCH_TIMEOUT_EN
      lat  = $urandom_range(1, TO - 1);
      hang = ($urandom_range(0, 5) == 0);
`else
      lat  = $urandom_range(1, 40);
`endif
      rr_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) begin
        core_clear_req = 1'b1;
        @(posedge Clk); #1;
        core_clear_req = 1'b0;
      end
      run_job(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
              lat, hang, $urandom_range(0, 3));
    end

    repeat (3) @(posedge Clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
